// File: rtl/mmul_arbiter.sv
// Two-requester round-robin front end for a shared 2x2 matrix multiplier.
// Optional WAIT-state abort is compiled in with the MMUL_ARB_TIMEOUT_EN macro.
module mmul_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [63:0] req_a_i,
    input  logic [63:0] req_b_i,
    output logic [1:0]  rsp_valid_o,
    input  logic [1:0]  rsp_ready_i,
    output logic [31:0] rsp_c_o,
    output logic        rsp_err_o,
    output logic        mul_start_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic [31:0] mul_c_i,
    input  logic        mul_done_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        prio_q, prio_d;
    logic        gnt_q, gnt_d;
    logic        gnt_sel;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] c_q, c_d;

`ifdef MMUL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             err_q, err_d;

    // cnt_inc is the 1-based index of the WAIT cycle currently in progress.
    assign cnt_inc = cnt_q + CNT_W'(1);
`endif

    // A lone requester always wins; a tie goes to the round-robin pointer.
    always_comb begin
        case (req_valid_i)
            2'b01:   gnt_sel = 1'b0;
            2'b10:   gnt_sel = 1'b1;
            default: gnt_sel = prio_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        gnt_d       = gnt_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        req_ready_o = 2'b00;
`ifdef MMUL_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    req_ready_o = 2'b01 << gnt_sel;
                    gnt_d       = gnt_sel;
                    prio_d      = ~gnt_sel;
                    a_d         = gnt_sel ? req_a_i[63:32] : req_a_i[31:0];
                    b_d         = gnt_sel ? req_b_i[63:32] : req_b_i[31:0];
                    state_d     = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef MMUL_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end

            ST_WAIT: begin
                // A done pulse arriving on the final allowed cycle still wins over the abort.
                if (mul_done_i) begin
                    c_d     = mul_c_i;
                    state_d = ST_RESP;
`ifdef MMUL_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    c_d     = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_inc;
`endif
                end
            end

            ST_RESP: begin
                if (rsp_ready_i[gnt_q]) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            gnt_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
`ifdef MMUL_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
`ifdef MMUL_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Operand registers only change on a grant, so they stay stable through ISSUE and WAIT.
    assign mul_start_o = (state_q == ST_ISSUE);
    assign mul_a_o     = a_q;
    assign mul_b_o     = b_q;
    assign rsp_valid_o = (state_q == ST_RESP) ? (2'b01 << gnt_q) : 2'b00;
    assign rsp_c_o     = c_q;
    assign busy_o      = (state_q != ST_IDLE);

`ifdef MMUL_ARB_TIMEOUT_EN
    assign rsp_err_o   = err_q & (state_q == ST_RESP);
`else
    assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mmul_arbiter.sv
// Scoreboard bench for mmul_arbiter with a behavioural 2x2 multiplier.
// Define MMUL_ARB_TIMEOUT_EN when compiling to also exercise the abort path.
module tb_mmul_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [63:0] req_a_i;
    logic [63:0] req_b_i;
    logic [1:0]  rsp_valid_o;
    logic [1:0]  rsp_ready_i;
    logic [31:0] rsp_c_o;
    logic        rsp_err_o;
    logic        mul_start_o;
    logic [31:0] mul_a_o;
    logic [31:0] mul_b_o;
    logic [31:0] mul_c_i;
    logic        mul_done_i;
    logic        busy_o;

    mmul_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_c_o     (rsp_c_o),
        .rsp_err_o   (rsp_err_o),
        .mul_start_o (mul_start_o),
        .mul_a_o     (mul_a_o),
        .mul_b_o     (mul_b_o),
        .mul_c_i     (mul_c_i),
        .mul_done_i  (mul_done_i),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          req;
        logic [31:0] c;
        logic        err;
        int          lat;
    } exp_t;

    exp_t respQ[$];
    int   grantQ[$];

    int total = 0;
    int bad   = 0;

    int          mulDelay  = 1;
    int          respDelay = 0;
    int          cd        = 0;
    logic [31:0] aLat = '0, bLat = '0;
    logic        modelDone = 1'b0;
    logic [31:0] modelC    = '0;
    logic        forceDone = 1'b0;

    int          cycleNo = 0, grantCycle = 0, expectGrantAt = 0;
    int          holdLeft = 0, startCount = 0, respCount = 0;
    logic        inResp = 1'b0, inFlight = 1'b0, prioM = 1'b0;
    logic [1:0]  pendingClear = 2'b00, heldV = 2'b00;
    logic [31:0] heldC = '0, startA = '0, startB = '0, lastC = '0;

    assign mul_done_i = modelDone | forceDone;
    assign mul_c_i    = forceDone ? 32'hDEAD_BEEF : modelC;

    // Reference 2x2 product with 8-bit wrap on every element.
    function automatic logic [31:0] matMul(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] c00, c01, c10, c11;
        c00 = a[7:0]   * b[7:0]  + a[15:8]  * b[23:16];
        c01 = a[7:0]   * b[15:8] + a[15:8]  * b[31:24];
        c10 = a[23:16] * b[7:0]  + a[31:24] * b[23:16];
        c11 = a[23:16] * b[15:8] + a[31:24] * b[31:24];
        return {c11, c10, c01, c00};
    endfunction

    // Multiplier model: done rises mulDelay cycles after the start cycle; 0 means never.
    always @(negedge clk) begin
        modelDone = 1'b0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                modelDone = 1'b1;
                modelC    = matMul(aLat, bLat);
            end
        end
        if (mul_start_o && mulDelay > 0) begin
            cd   = mulDelay;
            aLat = mul_a_o;
            bLat = mul_b_o;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, want, cycleNo);
        end
    endtask

    task automatic pushExp(input int r, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.req = r;
        e.err = 1'b0;
`ifdef MMUL_ARB_TIMEOUT_EN
        e.err = (mulDelay == 0 || mulDelay > TO);
`endif
        e.c   = e.err ? 32'h0 : matMul(a, b);
        e.lat = e.err ? TO + 2 : mulDelay + 2;
        respQ.push_back(e);
        grantQ.push_back(r);
    endtask

    // Drives a request set and predicts grant order with a private round-robin pointer.
    task automatic applyStimulus(input logic [1:0] mask, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [31:0] a1, input logic [31:0] b1);
        @(posedge clk);
        #1;
        req_a_i = {a1, a0};
        req_b_i = {b1, b0};
        if (mask == 2'b11) begin
            if (prioM == 1'b0) begin
                pushExp(0, a0, b0);
                pushExp(1, a1, b1);
            end else begin
                pushExp(1, a1, b1);
                pushExp(0, a0, b0);
            end
        end else if (mask == 2'b01) begin
            pushExp(0, a0, b0);
            prioM = 1'b1;
        end else if (mask == 2'b10) begin
            pushExp(1, a1, b1);
            prioM = 1'b0;
        end
        req_valid_i = mask;
    endtask

    // One clock of bench activity, observed at the falling edge.
    task automatic tick();
        logic [1:0] wantMask;
        exp_t       e;
        @(negedge clk);
        cycleNo++;
        req_valid_i  = req_valid_i & ~pendingClear;
        pendingClear = 2'b00;

        if (req_ready_o != 2'b00) begin
            wantMask = 2'b00;
            if (grantQ.size() > 0) wantMask = 2'b01 << grantQ.pop_front();
            checkOutput("grant", 128'(req_ready_o), 128'(wantMask));
            if (expectGrantAt > 0) checkOutput("grantGap", 128'(cycleNo), 128'(expectGrantAt));
            expectGrantAt = 0;
            grantCycle    = cycleNo;
            pendingClear  = req_ready_o;
        end

        if (mul_start_o) begin
            startCount++;
            startA   = mul_a_o;
            startB   = mul_b_o;
            inFlight = 1'b1;
        end else if (inFlight && rsp_valid_o == 2'b00) begin
            checkOutput("mulOperands", {64'h0, mul_a_o, mul_b_o}, {64'h0, startA, startB});
        end

        if (rsp_valid_o != 2'b00) begin
            inFlight = 1'b0;
            if (!inResp) begin
                inResp = 1'b1;
                respCount++;
                if (respQ.size() == 0) begin
                    checkOutput("spuriousRsp", 128'(rsp_valid_o), 128'(0));
                end else begin
                    e = respQ.pop_front();
                    checkOutput("rspValid", 128'(rsp_valid_o), 128'(2'b01 << e.req));
                    checkOutput("rspC", 128'(rsp_c_o), 128'(e.c));
                    checkOutput("rspErr", 128'(rsp_err_o), 128'(e.err));
                    checkOutput("latency", 128'(cycleNo - grantCycle), 128'(e.lat));
                end
                heldC    = rsp_c_o;
                heldV    = rsp_valid_o;
                lastC    = rsp_c_o;
                holdLeft = respDelay;
            end else begin
                checkOutput("holdC", 128'(rsp_c_o), 128'(heldC));
                checkOutput("holdValid", 128'(rsp_valid_o), 128'(heldV));
                checkOutput("holdNoGrant", 128'(req_ready_o), 128'(0));
            end
            if (holdLeft > 0) begin
                rsp_ready_i = ~rsp_valid_o;
                holdLeft--;
            end else begin
                rsp_ready_i   = rsp_valid_o;
                expectGrantAt = (req_valid_i != 2'b00) ? cycleNo + 1 : 0;
            end
        end else begin
            inResp      = 1'b0;
            rsp_ready_i = 2'b00;
            checkOutput("errIdle", 128'(rsp_err_o), 128'(0));
        end
    endtask

    task automatic runUntilIdle(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (respQ.size() == 0 && grantQ.size() == 0 && !busy_o && !inResp && req_valid_i == 2'b00)
                return;
        end
        checkOutput("cycleBudget", 128'(0), 128'(1));
        respQ.delete();
        grantQ.delete();
    endtask

    function automatic logic [127:0] allOutputs();
        return 128'({req_ready_o, rsp_valid_o, rsp_c_o, rsp_err_o, mul_start_o, mul_a_o, mul_b_o, busy_o});
    endfunction

    initial begin
        int s0;
        int s1;
        rst_n       = 1'b0;
        req_valid_i = 2'b00;
        req_a_i     = '0;
        req_b_i     = '0;
        rsp_ready_i = 2'b00;
        repeat (3) @(negedge clk);
        checkOutput("resetOut", allOutputs(), 128'(0));
        rst_n = 1'b1;
        tick();

        // Back-to-back minimum latency, single requester.
        mulDelay = 1;
        applyStimulus(2'b01, 32'h0403_0201, 32'h0807_0605, 32'h0, 32'h0);
        runUntilIdle(40);

        // Constant operands with a two-cycle multiplier.
        mulDelay = 2;
        s0 = startCount;
        applyStimulus(2'b01, 32'h0202_0202, 32'h0404_0404, 32'h0, 32'h0);
        runUntilIdle(40);
        checkOutput("startOnce", 128'(startCount - s0), 128'(1));
        checkOutput("c35", 128'(lastC), 128'(32'h1010_1010));

        mulDelay = 1;
        applyStimulus(2'b10, 32'h0, 32'h0, 32'hFF80_7F10, 32'h0203_0405);
        runUntilIdle(40);

        // Asynchronous reset while waiting on the multiplier.
        mulDelay = 3;
        applyStimulus(2'b01, 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midReset", allOutputs(), 128'(0));
        respQ.delete();
        grantQ.delete();
        inFlight     = 1'b0;
        inResp       = 1'b0;
        prioM        = 1'b0;
        pendingClear = 2'b00;
        req_valid_i  = 2'b00;
        rsp_ready_i  = 2'b00;
        @(negedge clk);
        rst_n     = 1'b1;
        forceDone = 1'b1;
        tick();
        forceDone = 1'b0;
        s1 = respCount;
        repeat (5) tick();
        checkOutput("postResetIdle", 128'({rsp_valid_o, busy_o}), 128'(0));
        checkOutput("postResetNoRsp", 128'(respCount - s1), 128'(0));

        // Simultaneous requests after reset, then a second pair.
        mulDelay = 1;
        applyStimulus(2'b11, 32'h0102_0304, 32'h0101_0101, 32'h0506_0708, 32'h0201_0102);
        runUntilIdle(60);
        applyStimulus(2'b11, 32'h0909_0909, 32'h0A0B_0C0D, 32'h1234_5678, 32'h8765_4321);
        runUntilIdle(60);

        // Requester stalls its response while the other waits.
        respDelay = 5;
        mulDelay  = 2;
        applyStimulus(2'b11, 32'h0F0E_0D0C, 32'h0302_0100, 32'h7777_7777, 32'h0303_0303);
        runUntilIdle(80);
        respDelay = 0;

        for (int k = 0; k < 6; k++) begin
            mulDelay  = 1 + int'($urandom_range(3));
            respDelay = int'($urandom_range(2));
            applyStimulus(2'(1 + $urandom_range(2)), $urandom, $urandom, $urandom, $urandom);
            runUntilIdle(80);
        end
        respDelay = 0;

`ifdef MMUL_ARB_TIMEOUT_EN
        mulDelay = 0;
        applyStimulus(2'b01, 32'h0505_0505, 32'h0606_0606, 32'h0, 32'h0);
        runUntilIdle(60);
        mulDelay = TO;
        applyStimulus(2'b10, 32'h0, 32'h0, 32'h0102_0304, 32'h0506_0708);
        runUntilIdle(60);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
